// File: rtl/score_display_pkg.sv
// Shared constants, FSM state type and 7-segment decode for the score display.
package score_display_pkg;

    localparam int DIGITS    = 4;
    localparam int SCORE_W   = 14;
    localparam int BCD_W     = 16;
    localparam int MAX_SCORE = 9999;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } conv_state_e;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD nibble; non-decimal nibbles go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-and-adjust step per clock.
// The working BCD register is stable once done pulses; the parent owns the
// committed copy.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam logic [SCORE_W-1:0] MAX_BIN   = SCORE_W'(MAX_SCORE);
    localparam logic [3:0]         LAST_ITER = 4'(SCORE_W - 1);

    conv_state_e        state_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         iter_q;
    logic [SCORE_W-1:0] shift_q;
    logic [BCD_W-1:0]   bcd_work_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift_d;

    // Add 3 to every nibble >= 5, then shift in the next binary bit.
    always_comb begin
        // NOTE: default assignment first so every path drives bcd_adj; no latch.
        bcd_adj = bcd_work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift_d = {bcd_adj[BCD_W-2:0], shift_q[SCORE_W-1]};
    end

    // Conversion FSM with registered busy/done; loads are ignored outside IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            iter_q     <= '0;
            shift_q    <= '0;
            bcd_work_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q    <= (bin > MAX_BIN) ? MAX_BIN : bin;
                        bcd_work_q <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_work_q <= bcd_shift_d;
                    shift_q    <= {shift_q[SCORE_W-2:0], 1'b0};
                    iter_q     <= iter_q + 4'd1;
                    if (iter_q == LAST_ITER) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // done leaves COMMIT as a single pulse so the parent writes once.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_work_q;

endmodule

// File: rtl/score_display.sv
// 4-digit multiplexed 7-segment score display: synchronises the scan and
// blink clocks, converts the score to BCD and scans one digit per scan tick
// with leading-zero suppression and per-digit blinking.
module score_display
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fast_clk,
    input  logic               blink_clk,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_load,
    input  logic [DIGITS-1:0]  blink_mask,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [DIGITS-1:0]  an,
    output logic               busy
);

    logic              fast_s1_q, fast_s2_q, fast_prev_q;
    logic              blink_s1_q, blink_s2_q;
    logic              scan_tick;
    logic              upd_q;
    logic [1:0]        idx_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [BCD_W-1:0]  upper;
    logic [3:0]        nib;
    logic              lead_zero;
    logic              blank;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (score_load),
        .bin   (score),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Two-flop synchronisers plus the previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fast_s1_q   <= 1'b0;
            fast_s2_q   <= 1'b0;
            fast_prev_q <= 1'b0;
            blink_s1_q  <= 1'b0;
            blink_s2_q  <= 1'b0;
        end else begin
            fast_s1_q   <= fast_clk;
            fast_s2_q   <= fast_s1_q;
            fast_prev_q <= fast_s2_q;
            blink_s1_q  <= blink_clk;
            blink_s2_q  <= blink_s1_q;
        end
    end

    assign scan_tick = fast_s2_q & ~fast_prev_q;

    // Next segment/anode pattern for the current index, including all blanking rules.
    always_comb begin
        upper     = bcd_q >> {idx_q, 2'b00};
        nib       = upper[3:0];
        lead_zero = (idx_q != 2'd0) && (upper == '0);
        blank     = lead_zero || (blink_mask[idx_q] && !blink_s2_q);
        seg_d     = blank ? SEG_BLANK : seg_decode(nib);
        an_d      = ~(4'b0001 << idx_q);
    end

    // Committed BCD value and the scan/output registers; seg and an move together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q <= '0;
            upd_q <= 1'b0;
            idx_q <= 2'd0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            upd_q <= scan_tick;
            if (conv_done) begin
                bcd_q <= conv_bcd;
            end
            if (upd_q) begin
                seg_q <= seg_d;
                an_q  <= an_d;
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: randomised scores, masks and blink
// phases compared against a decimal-arithmetic model of the display.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fast_clk = 1'b0;
    logic        blink_clk = 1'b1;
    logic [13:0] score = '0;
    logic        score_load = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int exp_idx = 0;

    logic [6:0] dec_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    score_display dut (
        .clk        (clk),
        .rst        (rst),
        .fast_clk   (fast_clk),
        .blink_clk  (blink_clk),
        .score      (score),
        .score_load (score_load),
        .blink_mask (blink_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int s);
        return (s > 9999) ? 9999 : s;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int v;
        v = clamp(s);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int s, input int d,
                                           input logic [3:0] mask, input logic blink);
        int v;
        int p;
        v = clamp(s);
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (d > 0 && v < p) return 7'h7F;
        if (mask[d] && !blink) return 7'h7F;
        return dec_tbl[(v / p) % 10];
    endfunction

    function automatic logic [3:0] exp_an(input int d);
        return 4'hF ^ (4'd1 << d);
    endfunction

    task automatic do_tick(output int slot);
        @(negedge clk) fast_clk = 1'b1;
        repeat (6) @(negedge clk);
        fast_clk = 1'b0;
        repeat (4) @(negedge clk);
        slot = exp_idx;
        exp_idx = (exp_idx + 1) % 4;
    endtask

    task automatic load_score(input int s);
        @(negedge clk);
        score = 14'(s);
        score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy still %b after %0d cycles", tag, busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int slot;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: seg=%h an=%h busy=%b dp=%b, want 7f f 0 1", seg, an, busy, dp);
        end
        rst = 1'b1;
        exp_idx = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F || an !== 4'hF) begin
            errors++;
            $display("FAIL dark_before_tick: seg=%h an=%h, want 7f f", seg, an);
        end
        do_tick(slot);
        checks++;
        if (seg !== 7'h40 || an !== 4'hE) begin
            errors++;
            $display("FAIL first_tick: seg=%h an=%h, want 40 e", seg, an);
        end
    endtask

    task automatic test_conversion;
        int cnt;
        int slot;
        load_score(1234);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 15) begin
            errors++;
            $display("FAIL busy_length: got %0d cycles, want 15", cnt);
        end
        checks++;
        if (dut.bcd_q !== 16'h0000) begin
            errors++;
            $display("FAIL bcd_early: bcd_q=%h after N+15, want 0000", dut.bcd_q);
        end
        @(negedge clk);
        checks++;
        if (dut.bcd_q !== to_bcd(1234)) begin
            errors++;
            $display("FAIL bcd_latency: bcd_q=%h after N+16, want %h", dut.bcd_q, to_bcd(1234));
        end
        for (int k = 0; k < 4; k++) begin
            do_tick(slot);
            checks++;
            if (seg !== exp_seg(1234, slot, blink_mask, blink_clk) || an !== exp_an(slot)) begin
                errors++;
                $display("FAIL scan_1234 slot%0d: seg=%h an=%h, want seg=%h an=%h",
                         slot, seg, an, exp_seg(1234, slot, blink_mask, blink_clk), exp_an(slot));
            end
        end
    endtask

    task automatic test_digits;
        int scores[5] = '{7, 0, 1005, 12000, 16383};
        int slot;
        for (int j = 0; j < 5; j++) begin
            load_score(scores[j]);
            wait_idle("digits");
            for (int k = 0; k < 4; k++) begin
                do_tick(slot);
                checks++;
                if (seg !== exp_seg(scores[j], slot, blink_mask, blink_clk) || an !== exp_an(slot)) begin
                    errors++;
                    $display("FAIL digits_%0d slot%0d: seg=%h an=%h, want seg=%h an=%h", scores[j],
                             slot, seg, an, exp_seg(scores[j], slot, blink_mask, blink_clk), exp_an(slot));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int slot;
        load_score(1234);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_conv: busy=%b, want 1", busy);
        end
        load_score(5678);
        wait_idle("back_to_back");
        checks++;
        if (dut.bcd_q !== to_bcd(1234)) begin
            errors++;
            $display("FAIL dropped_load: bcd_q=%h, want %h", dut.bcd_q, to_bcd(1234));
        end
        for (int k = 0; k < 4; k++) begin
            do_tick(slot);
            checks++;
            if (seg !== exp_seg(1234, slot, blink_mask, blink_clk) || an !== exp_an(slot)) begin
                errors++;
                $display("FAIL b2b_scan slot%0d: seg=%h an=%h, want seg=%h an=%h",
                         slot, seg, an, exp_seg(1234, slot, blink_mask, blink_clk), exp_an(slot));
            end
        end
    endtask

    task automatic test_reset_mid_conv;
        int slot;
        load_score(4321);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || an !== 4'hF || seg !== 7'h7F || dut.bcd_q !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_conv: busy=%b an=%h seg=%h bcd_q=%h, want 0 f 7f 0000",
                     busy, an, seg, dut.bcd_q);
        end
        @(negedge clk) rst = 1'b1;
        exp_idx = 0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            do_tick(slot);
            checks++;
            if (seg !== exp_seg(0, slot, blink_mask, blink_clk) || an !== exp_an(slot)) begin
                errors++;
                $display("FAIL after_abort slot%0d: seg=%h an=%h, want seg=%h an=%h",
                         slot, seg, an, exp_seg(0, slot, blink_mask, blink_clk), exp_an(slot));
            end
        end
    endtask

    task automatic test_blink;
        int slot;
        load_score(42);
        wait_idle("blink");
        blink_mask = 4'b0001;
        for (int ph = 0; ph < 2; ph++) begin
            blink_clk = ph[0];
            for (int k = 0; k < 4; k++) begin
                do_tick(slot);
                checks++;
                if (seg !== exp_seg(42, slot, blink_mask, blink_clk) || an !== exp_an(slot)) begin
                    errors++;
                    $display("FAIL blink_ph%0d slot%0d: seg=%h an=%h, want seg=%h an=%h", ph,
                             slot, seg, an, exp_seg(42, slot, blink_mask, blink_clk), exp_an(slot));
                end
            end
        end
        blink_mask = 4'b0000;
        blink_clk = 1'b1;
    endtask

    task automatic test_random;
        int s;
        int slot;
        for (int j = 0; j < 6; j++) begin
            s = int'($urandom_range(0, 16383));
            load_score(s);
            wait_idle("random");
            checks++;
            if (dut.bcd_q !== to_bcd(s)) begin
                errors++;
                $display("FAIL rand_bcd score=%0d: bcd_q=%h, want %h", s, dut.bcd_q, to_bcd(s));
            end
            blink_mask = 4'($urandom);
            blink_clk = 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                do_tick(slot);
                checks++;
                if (seg !== exp_seg(s, slot, blink_mask, blink_clk) || an !== exp_an(slot)) begin
                    errors++;
                    $display("FAIL rand_scan score=%0d slot%0d: seg=%h an=%h, want seg=%h an=%h", s,
                             slot, seg, an, exp_seg(s, slot, blink_mask, blink_clk), exp_an(slot));
                end
            end
        end
        blink_mask = 4'b0000;
        blink_clk = 1'b1;
    endtask

    initial begin
        test_reset;
        test_conversion;
        test_digits;
        test_back_to_back;
        test_reset_mid_conv;
        test_blink;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
